alu_result_stage: RTL and testbench

Execute-stage output buffer that sits directly downstream of the ALU in the RISC-V core. It accepts each ALU result (`y`) together with the ALU branch status flags and the instruction's destination and branch fields. It holds them in a 2-entry skid FIFO toward writeback, using valid/ready handshakes on both sides. It also resolves conditional branches from the flags and issues a one-cycle PC redirect.

---
 rtl/alu_result_stage.sv | 135 +++++++++++++
 tb/tb_alu_result_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Execute-stage output buffer: 2-entry skid FIFO of ALU results toward writeback,
// with optional branch resolution / PC redirect enabled by ALU_RESULT_BR_RESOLVE_EN.
module alu_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [2:0]       in_bsr,
    input  logic [4:0]       in_rd,
    input  logic             in_we,
    input  logic             in_is_branch,
    input  logic [2:0]       in_funct3,
    input  logic [WIDTH-1:0] in_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [4:0]       out_rd,
    output logic             out_we,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc
);

    logic [WIDTH-1:0] mem_result_q [2];
    logic [4:0]       mem_rd_q     [2];
    logic             mem_we_q     [2];
    logic             wptr_q;
    logic             rptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push_s;
    logic             pop_s;
    logic             we_gated_s;

    assign in_ready   = (count_q != 2'd2);
    assign out_valid  = (count_q != 2'd0);
    assign push_s     = in_valid && in_ready;
    assign pop_s      = out_valid && out_ready;
    assign we_gated_s = in_we && (in_rd != 5'd0);

    assign out_result = mem_result_q[rptr_q];
    assign out_rd     = mem_rd_q[rptr_q];
    assign out_we     = mem_we_q[rptr_q];

    // Occupancy next-state from the push/pop pair
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_result_q[i] <= '0;
                mem_rd_q[i]     <= 5'd0;
                mem_we_q[i]     <= 1'b0;
            end
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_s) begin
                mem_result_q[wptr_q] <= in_result;
                mem_rd_q[wptr_q]     <= in_rd;
                mem_we_q[wptr_q]     <= we_gated_s;
                wptr_q               <= ~wptr_q;
            end
            if (pop_s) begin
                rptr_q <= ~rptr_q;
            end
            count_q <= count_d;
        end
    end

`ifdef ALU_RESULT_BR_RESOLVE_EN
    logic             redirect_valid_q;
    logic             redirect_valid_d;
    logic [WIDTH-1:0] redirect_pc_q;
    logic [WIDTH-1:0] redirect_pc_d;

    // bsr: [0] eq, [1] signed lt, [2] unsigned lt
    function automatic logic br_taken(input logic [2:0] funct3, input logic [2:0] bsr);
        logic taken;
        case (funct3)
            3'b000:  taken = bsr[0];
            3'b001:  taken = ~bsr[0];
            3'b100:  taken = bsr[1];
            3'b101:  taken = ~bsr[1];
            3'b110:  taken = bsr[2];
            3'b111:  taken = ~bsr[2];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Resolve once at push so a stalled branch cannot redirect twice
    always_comb begin
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (push_s && in_is_branch && br_taken(in_funct3, in_bsr)) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = in_target;
        end else begin
            redirect_valid_d = 1'b0;
        end
    end

    // Single-cycle redirect pulse register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
`else
    logic unused_br_s;
    assign unused_br_s    = ^{in_bsr, in_is_branch, in_funct3, in_target};
    assign redirect_valid = 1'b0;
    assign redirect_pc    = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage; branch expectations
// follow ALU_RESULT_BR_RESOLVE_EN.
module tb_alu_result_stage;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [2:0]       in_bsr;
    logic [4:0]       in_rd;
    logic             in_we;
    logic             in_is_branch;
    logic [2:0]       in_funct3;
    logic [WIDTH-1:0] in_target;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [4:0]       out_rd;
    logic             out_we;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;

    int n_asserts = 0;
    int n_fails   = 0;

    alu_result_stage #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_bsr(in_bsr), .in_rd(in_rd), .in_we(in_we),
        .in_is_branch(in_is_branch), .in_funct3(in_funct3), .in_target(in_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_we(out_we),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd, input logic we);
        in_valid  = v;
        in_result = res;
        in_rd     = rd;
        in_we     = we;
    endtask

    task automatic drive_br(input logic [2:0] f3, input logic [2:0] bsr, input logic [31:0] tgt);
        in_is_branch = 1'b1;
        in_funct3    = f3;
        in_bsr       = bsr;
        in_target    = tgt;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        in_is_branch = 1'b0;
        in_funct3    = 3'b000;
        in_bsr       = 3'b000;
        in_target    = 32'h0;
        out_ready    = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_redirect_valid", redirect_valid, 1'b0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_rd", out_rd, 5'd0);
        check("rst_out_we", out_we, 1'b0);
        rst_n = 1'b1;
        step();

        // single transfer
        out_ready = 1'b1;
        drive(1'b1, 32'h14, 5'd5, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        check("single_valid", out_valid, 1'b1);
        check("single_result", out_result, 32'h14);
        check("single_rd", out_rd, 5'd5);
        check("single_we", out_we, 1'b1);
        step();
        check("single_empty", out_valid, 1'b0);
        check("single_in_ready", in_ready, 1'b1);

        // fill and backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 5'd1, 1'b1);
        step();
        check("fill1_in_ready", in_ready, 1'b1);
        drive(1'b1, 32'hB, 5'd2, 1'b1);
        step();
        check("full_in_ready", in_ready, 1'b0);
        drive(1'b1, 32'hC, 5'd3, 1'b1);
        step();
        check("held_in_ready", in_ready, 1'b0);
        check("held_head", out_result, 32'hA);
        check("held_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        step();
        check("drain_in_ready", in_ready, 1'b1);
        check("drain_head_b", out_result, 32'hB);
        check("drain_rd_b", out_rd, 5'd2);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        check("drain_head_c", out_result, 32'hC);
        check("drain_rd_c", out_rd, 5'd3);
        check("drain_valid_c", out_valid, 1'b1);
        step();
        check("drain_empty", out_valid, 1'b0);
        check("drain_ready_back", in_ready, 1'b1);

        // x0 write gating
        drive(1'b1, 32'h55, 5'd0, 1'b1);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        check("x0_valid", out_valid, 1'b1);
        check("x0_we", out_we, 1'b0);
        check("x0_result", out_result, 32'h55);
        step();

        // branch resolution
        drive(1'b1, 32'h1000, 5'd0, 1'b0);
        drive_br(3'b001, 3'b001, 32'h40);
        step();
        check("bne_no_redirect", redirect_valid, 1'b0);
        drive_br(3'b100, 3'b010, 32'h80);
        step();
`ifdef ALU_RESULT_BR_RESOLVE_EN
        check("blt_redirect_valid", redirect_valid, 1'b1);
        check("blt_redirect_pc", redirect_pc, 32'h80);
`else
        check("blt_redirect_off", redirect_valid, 1'b0);
        check("blt_redirect_pc_off", redirect_pc, 32'h0);
`endif
        drive_br(3'b111, 3'b100, 32'hC0);
        step();
        check("bgeu_no_redirect", redirect_valid, 1'b0);
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        in_is_branch = 1'b0;
        step();
        check("br_redirect_idle", redirect_valid, 1'b0);
        check("br_drained", out_valid, 1'b0);

        // simultaneous push/pop at count 1, wraps pointers
        out_ready = 1'b0;
        drive(1'b1, 32'h100, 5'd2, 1'b1);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h101 + i, 5'd2, 1'b1);
            step();
            check("stream_valid", out_valid, 1'b1);
            check("stream_in_ready", in_ready, 1'b1);
            check("stream_result", out_result, 32'h101 + i);
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        step();
        check("stream_empty", out_valid, 1'b0);

        // mid-operation asynchronous reset
        out_ready = 1'b0;
        drive(1'b1, 32'h200, 5'd4, 1'b1);
        step();
        drive(1'b1, 32'h201, 5'd0, 1'b0);
        drive_br(3'b000, 3'b001, 32'h300);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        in_is_branch = 1'b0;
        check("pre_rst_full", in_ready, 1'b0);
`ifdef ALU_RESULT_BR_RESOLVE_EN
        check("pre_rst_redirect", redirect_valid, 1'b1);
        check("pre_rst_redirect_pc", redirect_pc, 32'h300);
`else
        check("pre_rst_redirect_off", redirect_valid, 1'b0);
`endif
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_redirect", redirect_valid, 1'b0);
        check("async_rst_in_ready", in_ready, 1'b1);
        check("async_rst_result", out_result, 32'h0);
        rst_n = 1'b1;
        step();
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_redirect", redirect_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
